// File: rtl/lr_inference_scheduler.sv
// rtl/lr_inference_scheduler.sv - round-robin front-end sequencer for the logistic regression core
// Optional feature: define LR_SCHED_PERF_CNT_EN to add the perf_count response counter.
module lr_inference_scheduler #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_W       = 32,
  parameter int CORE_LATENCY = 1,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_feature0,
  input  logic [NUM_REQ*DATA_W-1:0] req_feature1,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      core_read_enable,
  output logic [DATA_W-1:0]         core_feature0,
  output logic [DATA_W-1:0]         core_feature1,
  input  logic [DATA_W-1:0]         core_result,
  output logic                      busy
`ifdef LR_SCHED_PERF_CNT_EN
  ,output logic [31:0]              perf_count
`endif
);

  localparam int CNT_W = $clog2(CORE_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_f0;
  logic [DATA_W-1:0]   r_f1;
  logic [DATA_W-1:0]   r_data;
  logic [CNT_W-1:0]    r_cnt;
  logic [ID_W-1:0]     w_grant;
  logic [ID_W-1:0]     w_ptr_next;
  logic [ID_W:0]       w_k;
  logic                w_found;
  logic                w_accept;

  // First valid requester at or after the priority pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_k     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_k = {1'b0, r_ptr} + (ID_W+1)'(i);
      if (w_k >= (ID_W+1)'(NUM_REQ)) w_k = w_k - (ID_W+1)'(NUM_REQ);
      if (!w_found && req_valid[w_k[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_k[ID_W-1:0];
      end
    end
  end

  assign w_ptr_next = (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + ID_W'(1);
  assign w_accept   = (r_state == S_IDLE) && w_found && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (r_cnt == CNT_W'(1)) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready        = '0;
    core_read_enable = 1'b0;
    rsp_valid        = 1'b0;
    busy             = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (w_accept) req_ready = NUM_REQ'(1) << w_grant;
      S_ISSUE: core_read_enable = 1'b1;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr  <= '0;
      r_id   <= '0;
      r_f0   <= '0;
      r_f1   <= '0;
      r_data <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_f0  <= req_feature0[w_grant*DATA_W +: DATA_W];
        r_f1  <= req_feature1[w_grant*DATA_W +: DATA_W];
        r_id  <= w_grant;
        r_ptr <= w_ptr_next;
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= CNT_W'(CORE_LATENCY);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) r_data <= core_result;
      end
    end
  end

`ifdef LR_SCHED_PERF_CNT_EN
  logic [31:0] r_perf_count;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                r_perf_count <= '0;
    else if (r_state == S_RESP && rsp_ready)   r_perf_count <= r_perf_count + 32'd1;
  end
  assign perf_count = r_perf_count;
`endif

  assign core_feature0 = r_f0;
  assign core_feature1 = r_f1;
  assign rsp_data      = r_data;
  assign rsp_id        = r_id;

endmodule

// File: tb/tb_lr_inference_scheduler.sv
// tb/tb_lr_inference_scheduler.sv - self-checking bench for lr_inference_scheduler
module tb_lr_inference_scheduler;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_f0;
  logic [63:0] req_f1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [0:0]  rsp_id;
  logic        core_re;
  logic [31:0] core_f0;
  logic [31:0] core_f1;
  logic [31:0] core_result;
  logic        busy;

  logic [2:0]  rv4;
  logic [2:0]  rdy4;
  logic [95:0] f0_4;
  logic [95:0] f1_4;
  logic        rsp_valid4;
  logic [31:0] rsp_data4;
  logic [1:0]  rsp_id4;
  logic        re4;
  logic [31:0] cf0_4;
  logic [31:0] cf1_4;
  logic        busy4;
  logic [31:0] cyc;

`ifdef LR_SCHED_PERF_CNT_EN
  logic [31:0] perf_count;
  logic [31:0] perf_count4;
`endif

  int n_chk;
  int n_err;
  int n_resp;
  int m_ptr;

  // Core model for the latency-1 instance: result is the sum of the features.
  assign core_result = core_f0 + core_f1;

  lr_inference_scheduler #(.NUM_REQ(2), .DATA_W(32), .CORE_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_feature0(req_f0), .req_feature1(req_f1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .core_read_enable(core_re), .core_feature0(core_f0), .core_feature1(core_f1),
    .core_result(core_result), .busy(busy)
`ifdef LR_SCHED_PERF_CNT_EN
    , .perf_count(perf_count)
`endif
  );

  lr_inference_scheduler #(.NUM_REQ(3), .DATA_W(32), .CORE_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset),
    .req_valid(rv4), .req_ready(rdy4),
    .req_feature0(f0_4), .req_feature1(f1_4),
    .rsp_valid(rsp_valid4), .rsp_ready(1'b1),
    .rsp_data(rsp_data4), .rsp_id(rsp_id4),
    .core_read_enable(re4), .core_feature0(cf0_4), .core_feature1(cf1_4),
    .core_result(cyc), .busy(busy4)
`ifdef LR_SCHED_PERF_CNT_EN
    , .perf_count(perf_count4)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 32'd1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_grant(input logic [1:0] mask, input int ptr);
    for (int i = 0; i < 2; i++) begin
      int k;
      k = (ptr + i) % 2;
      if (mask[k]) return k;
    end
    return -1;
  endfunction

  // Called just after a falling edge; returns just after a falling edge with the DUT idle.
  task automatic run_txn(input logic [1:0] mask, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1, input int eid,
                         input logic [31:0] edata, input int bp, input logic [1:0] pend);
    int t;
    logic re_extra;
    logic [31:0] ef0, ef1;
    logic [1:0] erdy;
    ef0  = (eid == 1) ? a1 : a0;
    ef1  = (eid == 1) ? b1 : b0;
    erdy = 2'b01 << eid;
    req_valid = mask;
    req_f0 = {a1, a0};
    req_f1 = {b1, b0};
    rsp_ready = (bp == 0);
    #1;
    t = 0;
    while (req_ready == 2'b00 && t < 20) begin
      @(negedge clk); #1; t++;
    end
    chk("req_ready_grant", 64'(req_ready), 64'(erdy));
    @(negedge clk);
    req_valid = pend;
    #1;
    chk("issue_read_enable", 64'(core_re), 64'd1);
    chk("issue_feature0", 64'(core_f0), 64'(ef0));
    chk("issue_feature1", 64'(core_f1), 64'(ef1));
    t = 1;
    re_extra = 1'b0;
    do begin
      @(negedge clk); #1; t++;
      if (core_re) re_extra = 1'b1;
    end while (!rsp_valid && t < 20);
    chk("rsp_latency", 64'(t), 64'd3);
    chk("read_enable_single_pulse", 64'(re_extra), 64'd0);
    chk("rsp_data", 64'(rsp_data), 64'(edata));
    chk("rsp_id", 64'(rsp_id), 64'(eid));
    chk("resp_feature0_stable", 64'(core_f0), 64'(ef0));
    for (int j = 0; j < bp; j++) begin
      @(negedge clk); #1;
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_data", 64'(rsp_data), 64'(edata));
      chk("bp_rsp_id", 64'(rsp_id), 64'(eid));
      chk("bp_no_req_ready", 64'(req_ready), 64'd0);
      chk("bp_no_read_enable", 64'(core_re), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    chk("idle_after_rsp", 64'(busy), 64'd0);
    n_resp++;
    m_ptr = (eid + 1) % 2;
  endtask

  typedef struct {
    logic [1:0]  mask;
    logic [31:0] a0, b0, a1, b1;
    int          eid;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int t;
    int c0;
    logic [1:0]  mask;
    logic [31:0] a0, b0, a1, b1;
    int eid;

    n_chk = 0; n_err = 0; n_resp = 0; m_ptr = 0;
    cyc = 0;
    reset = 1'b0;
    req_valid = 2'b00; req_f0 = '0; req_f1 = '0; rsp_ready = 1'b0;
    rv4 = 3'b000; f0_4 = '0; f1_4 = '0;

    tbl[0] = '{2'b01, 32'd12,         32'd8, 32'd0,   32'd0, 0, 32'h14};
    tbl[1] = '{2'b11, 32'd1,          32'd2, 32'd100, 32'd5, 1, 32'd105};
    tbl[2] = '{2'b10, 32'd0,          32'd0, 32'd7,   32'd9, 1, 32'd16};
    tbl[3] = '{2'b11, 32'hFFFF_FFFF,  32'd2, 32'd3,   32'd3, 0, 32'd1};
    tbl[4] = '{2'b01, 32'd5,          32'd5, 32'd0,   32'd0, 0, 32'd10};

    @(negedge clk); #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_read_enable", 64'(core_re), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_core_f0", 64'(core_f0), 64'd0);
    chk("reset_core_f1", 64'(core_f1), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("post_reset_idle", 64'(busy), 64'd0);

    for (int i = 0; i < 5; i++)
      run_txn(tbl[i].mask, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1,
              tbl[i].eid, tbl[i].data, 0, 2'b00);

    // Both requesters held valid: grants alternate.
    for (int i = 0; i < 4; i++) begin
      eid = exp_grant(2'b11, m_ptr);
      chk("rr_model_order", 64'(eid), 64'(m_ptr));
      run_txn(2'b11, 32'd10 + i, 32'd1, 32'd20 + i, 32'd2, eid,
              (eid == 1) ? 32'd22 + i : 32'd11 + i, 0, (eid == 1) ? 2'b01 : 2'b10);
    end

    // Response backpressure with the other requester waiting.
    eid = exp_grant(2'b11, m_ptr);
    run_txn(2'b11, 32'd40, 32'd2, 32'd50, 32'd3, eid, (eid == 1) ? 32'd53 : 32'd42, 5,
            (eid == 1) ? 2'b01 : 2'b10);
    chk("pending_req_ready_after_rsp", 64'(req_ready), (eid == 1) ? 64'd1 : 64'd2);
    run_txn((eid == 1) ? 2'b01 : 2'b10, 32'd40, 32'd2, 32'd50, 32'd3, 1 - eid,
            (eid == 1) ? 32'd42 : 32'd53, 0, 2'b00);

    // Reset while waiting on the core drops the transaction.
    req_valid = 2'b10; req_f0 = {32'd9, 32'd9}; req_f1 = {32'd9, 32'd9}; rsp_ready = 1'b1;
    #1; t = 0;
    while (req_ready == 2'b00 && t < 20) begin @(negedge clk); #1; t++; end
    chk("pre_reset_grant", 64'(req_ready), 64'd2);
    @(negedge clk); @(negedge clk); #1;
    chk("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("async_reset_busy", 64'(busy), 64'd0);
    chk("async_reset_core_f0", 64'(core_f0), 64'd0);
    chk("async_reset_core_f1", 64'(core_f1), 64'd0);
    chk("async_reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async_reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("async_reset_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk); @(negedge clk); #1;
    chk("in_reset_no_rsp", 64'(rsp_valid), 64'd0);
    reset = 1'b1;
    m_ptr = 0;
    n_resp = 0;
    #1;
    chk("release_no_rsp", 64'(rsp_valid), 64'd0);
    run_txn(2'b11, 32'd30, 32'd4, 32'd9, 32'd9, exp_grant(2'b11, m_ptr), 32'd34, 0, 2'b10);
    run_txn(2'b10, 32'd30, 32'd4, 32'd9, 32'd9, 1, 32'd18, 0, 2'b00);

    // Randomized transactions against the model.
    for (int i = 0; i < 30; i++) begin
      mask = 2'($urandom_range(1, 3));
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      eid = exp_grant(mask, m_ptr);
      run_txn(mask, a0, b0, a1, b1, eid, (eid == 1) ? a1 + b1 : a0 + b0,
              int'($urandom_range(0, 3)), 2'b00);
    end

    // Latency-4 instance: result sampled on the last wait cycle.
    rv4 = 3'b100; f0_4 = {32'd77, 32'd0, 32'd0}; f1_4 = {32'd88, 32'd0, 32'd0};
    #1; t = 0;
    while (rdy4 == 3'b000 && t < 20) begin @(negedge clk); #1; t++; end
    chk("lat4_grant", 64'(rdy4), 64'd4);
    c0 = int'(cyc);
    @(negedge clk);
    rv4 = 3'b000;
    #1;
    chk("lat4_read_enable", 64'(re4), 64'd1);
    chk("lat4_feature0", 64'(cf0_4), 64'd77);
    chk("lat4_feature1", 64'(cf1_4), 64'd88);
    t = 1;
    do begin @(negedge clk); #1; t++; end while (!rsp_valid4 && t < 30);
    chk("lat4_rsp_latency", 64'(t), 64'd6);
    chk("lat4_rsp_data", 64'(rsp_data4), 64'(c0 + 5));
    chk("lat4_rsp_id", 64'(rsp_id4), 64'd2);
    @(negedge clk); #1;
    chk("lat4_idle", 64'(busy4), 64'd0);

`ifdef LR_SCHED_PERF_CNT_EN
    chk("perf_count", 64'(perf_count), 64'(n_resp));
    dut.r_perf_count = 32'hFFFF_FFFF;
    run_txn(2'b01, 32'd1, 32'd1, 32'd0, 32'd0, exp_grant(2'b01, m_ptr), 32'd2, 0, 2'b00);
    chk("perf_count_wrap", 64'(perf_count), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
